dma_ctrl: RTL

DMA_CTRL -- requirements
Module: dma_ctrl

---
 rtl/dma_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dma_ctrl.sv
// dma_ctrl: sprite (OAM) and DMC DMA controller for a 6502-style CPU bus.
//   Inputs : clk, reset (async, active-high), ce (CPU-cycle enable),
//            odd_or_even (0 = get cycle, 1 = put cycle), spr_trig/spr_page
//            ($4014 write), apu_req/apu_addr (DMC fetch request), cpu_read,
//            mem_rdata (bus read data).
//   Outputs: pause_cpu (RDY hold), bus_own, dma_addr, dma_we, dma_wdata,
//            apu_ack (DMC fetch acknowledge).
// All outputs come from flops updated on ce edges. Each one describes the
// CPU cycle that the edge has just started.
module dma_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        odd_or_even,
  input  logic        spr_trig,
  input  logic [7:0]  spr_page,
  input  logic        apu_req,
  input  logic [15:0] apu_addr,
  input  logic        cpu_read,
  input  logic [7:0]  mem_rdata,
  output logic        pause_cpu,
  output logic        bus_own,
  output logic [15:0] dma_addr,
  output logic        dma_we,
  output logic [7:0]  dma_wdata,
  output logic        apu_ack
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] OAM_DATA = AW'(16'h2004);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HALT   = 3'd1,
    ALIGN  = 3'd2,
    SPR_RD = 3'd3,
    SPR_WR = 3'd4,
    DMC_RD = 3'd5
  } state_t;

  state_t        state;
  state_t        nxt;
  logic          spr_pend;
  logic [DW-1:0] page;
  logic [DW-1:0] idx;
  logic [DW-1:0] idx_nxt;
  logic [DW-1:0] dbuf;
  logic          last_wr;
  logic          pend_eff;
  logic          req_eff;
  logic          trig_take;

  // Choose the next cycle once the CPU is halted. odd_or_even is the parity
  // of the cycle now ending, so the next cycle is a get when it is 1.
  function automatic state_t advance(input logic pend, input logic req,
                                     input logic next_get);
    state_t s;
    if (!pend && !req)  s = IDLE;
    else if (!next_get) s = ALIGN;
    else if (req)       s = DMC_RD;
    else                s = SPR_RD;
    return s;
  endfunction

  // The final sprite write already counts as "no sprite pending", and a DMC
  // request is considered served by the cycle that acknowledges it.
  assign last_wr   = (state == SPR_WR) && (idx == 8'hFF);
  assign pend_eff  = spr_pend && !last_wr;
  assign req_eff   = apu_req && (state != DMC_RD);
  assign trig_take = spr_trig && !spr_pend;

  // Next-state decode
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (spr_pend || apu_req) nxt = HALT;
      HALT: begin
        if (cpu_read)                 nxt = advance(pend_eff, req_eff, odd_or_even);
        else if (!spr_pend && !apu_req) nxt = IDLE;
      end
      SPR_RD:  nxt = SPR_WR;
      default: nxt = advance(pend_eff, req_eff, odd_or_even);
    endcase
  end

  // Sprite byte index; a trigger is only taken when no sprite transfer is in
  // flight, so it never collides with the post-write increment.
  always_comb begin
    idx_nxt = idx;
    if (trig_take)              idx_nxt = '0;
    else if (state == SPR_WR)   idx_nxt = idx + DW'(1);
  end

  // State, transfer context and registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      spr_pend  <= 1'b0;
      page      <= '0;
      idx       <= '0;
      dbuf      <= '0;
      pause_cpu <= 1'b0;
      bus_own   <= 1'b0;
      dma_addr  <= '0;
      dma_we    <= 1'b0;
      apu_ack   <= 1'b0;
    end else if (ce) begin
      state <= nxt;
      idx   <= idx_nxt;
      if (trig_take) begin
        spr_pend <= 1'b1;
        page     <= spr_page;
      end else if (last_wr) begin
        spr_pend <= 1'b0;
      end
      if (state == SPR_RD) dbuf <= mem_rdata;
      pause_cpu <= (nxt != IDLE);
      bus_own   <= (nxt == SPR_RD) || (nxt == SPR_WR) || (nxt == DMC_RD);
      dma_we    <= (nxt == SPR_WR);
      apu_ack   <= (nxt == DMC_RD);
      case (nxt)
        DMC_RD:  dma_addr <= apu_addr;
        SPR_RD:  dma_addr <= {page, idx_nxt};
        SPR_WR:  dma_addr <= OAM_DATA;
        default: dma_addr <= '0;
      endcase
    end
  end

  assign dma_wdata = dbuf;

endmodule
